// File: rtl/dota_trim_cal_pkg.sv
// dota_pkg: shared types and helpers for the dota_trim_cal calibration engine.
//   state_t      - calibration FSM states
//   ch_w()       - channel-index width, never below 1
//   midscale()   - midscale trim code (1 << (w-1))
//   DECIDE_CYC   - comparator sampling cycles per decision
//   bit_cyc()    - cycles spent per trim bit (settling + decision)
// Optional feature macro: DOTA_CAL_MAJ3_EN (3-sample majority decision).
package dota_pkg;

    // NEXT_CH is kept for reference only; its work happens on the DECIDE edge.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_DECIDE,
        ST_NEXT_CH,
        ST_DONE
    } state_t;

    function automatic int unsigned ch_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int unsigned midscale(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

`ifdef DOTA_CAL_MAJ3_EN
    localparam int unsigned DECIDE_CYC = 3;
`else
    localparam int unsigned DECIDE_CYC = 1;
`endif

    function automatic int unsigned bit_cyc(input int unsigned settle);
        return settle + DECIDE_CYC;
    endfunction

endpackage

// File: rtl/dota_trim_cal_if.sv
// dota_trim_cal_if: control/status bundle between tile control and the
// calibration engine.
//   start, cmp_in, wr_en, wr_ch, wr_code      - driven by master
//   trim_code, cur_ch, busy, done, cal_err    - driven by slave (engine)
interface dota_trim_cal_if #(
    parameter int unsigned N_CH   = 4,
    parameter int unsigned TRIM_W = 6
);
    import dota_pkg::*;

    localparam int unsigned CH_W = ch_w(N_CH);

    logic                     start;
    logic [N_CH-1:0]          cmp_in;
    logic                     wr_en;
    logic [CH_W-1:0]          wr_ch;
    logic [TRIM_W-1:0]        wr_code;
    logic [N_CH*TRIM_W-1:0]   trim_code;
    logic [CH_W-1:0]          cur_ch;
    logic                     busy;
    logic                     done;
    logic [N_CH-1:0]          cal_err;

    modport master (
        output start, cmp_in, wr_en, wr_ch, wr_code,
        input  trim_code, cur_ch, busy, done, cal_err
    );

    modport slave (
        input  start, cmp_in, wr_en, wr_ch, wr_code,
        output trim_code, cur_ch, busy, done, cal_err
    );

endinterface

// File: rtl/dota_trim_cal_settle_timer.sv
// dota_settle_timer: settling counter. Holds CYC while load is high, counts
// down while load is low; expired is high on the last settling cycle.
//   clk, rst  - clock, synchronous active-high reset
//   load      - reload request (high whenever not settling)
//   expired   - final settling cycle strobe
module dota_settle_timer #(
    parameter int unsigned CYC = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);
    localparam int unsigned W = $clog2(CYC + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            cnt <= W'(CYC);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expired = !load && (cnt == W'(1));

endmodule

// File: rtl/dota_trim_cal.sv
// dota_trim_cal: N-channel SAR offset-trim calibration engine for the OTA array.
// Channels are searched MSB-first, one after another; manual trim writes are
// accepted only while idle.
//   clk, rst  - clock, synchronous active-high reset
//   bus       - dota_trim_cal_if.slave (start/cmp_in/wr_* in;
//               trim_code/cur_ch/busy/done/cal_err out)
// Optional feature macro: DOTA_CAL_MAJ3_EN (2-of-3 majority per decision).
module dota_trim_cal #(
    parameter int unsigned N_CH       = 4,
    parameter int unsigned TRIM_W     = 6,
    parameter int unsigned SETTLE_CYC = 8
) (
    input  logic           clk,
    input  logic           rst,
    dota_trim_cal_if.slave bus
);
    import dota_pkg::*;

    localparam int unsigned CH_W  = ch_w(N_CH);
    localparam int unsigned BIT_W = $clog2(TRIM_W);
    localparam logic [TRIM_W-1:0] MID     = TRIM_W'(midscale(TRIM_W));
    localparam logic [BIT_W-1:0]  TOP_BIT = BIT_W'(TRIM_W - 1);
    localparam logic [CH_W-1:0]   LAST_CH = CH_W'(N_CH - 1);

    state_t              state;
    logic [TRIM_W-1:0]   code [N_CH];
    logic [CH_W-1:0]     ch;
    logic [BIT_W-1:0]    bit_idx;
    logic                busy_q;
    logic                done_q;
    logic [N_CH-1:0]     err_q;
    logic                settle_exp;
    logic                cmp_now;
    logic                cmp_dec;
    logic                dec_fire;
    logic [TRIM_W-1:0]   dec_code;
    logic [N_CH*TRIM_W-1:0] trim_flat;

`ifdef DOTA_CAL_MAJ3_EN
    logic [1:0] dsub;
    logic [1:0] smp;
`endif

    dota_settle_timer #(.CYC(SETTLE_CYC)) u_settle (
        .clk     (clk),
        .rst     (rst),
        .load    (state != ST_SETTLE),
        .expired (settle_exp)
    );

    // Decision for the current bit and the trial code it produces.
    always_comb begin
        cmp_now = bus.cmp_in[ch];
`ifdef DOTA_CAL_MAJ3_EN
        cmp_dec  = (smp[0] & smp[1]) | (smp[0] & cmp_now) | (smp[1] & cmp_now);
        dec_fire = (dsub == 2'(DECIDE_CYC - 1));
`else
        cmp_dec  = cmp_now;
        dec_fire = 1'b1;
`endif
        dec_code = code[ch];
        if (cmp_dec) begin
            dec_code[bit_idx] = 1'b0;
        end
        if (bit_idx != '0) begin
            dec_code[bit_idx - 1'b1] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            ch      <= '0;
            bit_idx <= TOP_BIT;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
            for (int unsigned c = 0; c < N_CH; c++) begin
                code[c] <= MID;
            end
`ifdef DOTA_CAL_MAJ3_EN
            dsub <= '0;
            smp  <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        err_q   <= '0;
                        ch      <= '0;
                        bit_idx <= TOP_BIT;
                        code[0] <= MID;
                        busy_q  <= 1'b1;
                        state   <= ST_SETTLE;
                    end else if (bus.wr_en && (int'(bus.wr_ch) < int'(N_CH))) begin
                        code[bus.wr_ch] <= bus.wr_code;
                    end
                end
                ST_SETTLE: begin
                    if (settle_exp) begin
                        state <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
`ifdef DOTA_CAL_MAJ3_EN
                    if (!dec_fire) begin
                        smp[dsub[0]] <= cmp_now;
                        dsub         <= dsub + 1'b1;
                    end else begin
                        dsub <= '0;
                    end
`endif
                    if (dec_fire) begin
                        code[ch] <= dec_code;
                        if (bit_idx != '0) begin
                            bit_idx <= bit_idx - 1'b1;
                            state   <= ST_SETTLE;
                        end else begin
                            // Channel finished: flag saturation and move on
                            // within this same edge.
                            err_q[ch] <= (dec_code == '0) || (dec_code == '1);
                            if (ch != LAST_CH) begin
                                ch              <= ch + 1'b1;
                                code[ch + 1'b1] <= MID;
                                bit_idx         <= TOP_BIT;
                                state           <= ST_SETTLE;
                            end else begin
                                ch     <= '0;
                                busy_q <= 1'b0;
                                done_q <= 1'b1;
                                state  <= ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    always_comb begin
        trim_flat = '0;
        for (int unsigned c = 0; c < N_CH; c++) begin
            trim_flat[c*TRIM_W +: TRIM_W] = code[c];
        end
        bus.trim_code = trim_flat;
        bus.cur_ch    = ch;
        bus.busy      = busy_q;
        bus.done      = done_q;
        bus.cal_err   = err_q;
    end

endmodule

// File: tb/tb_dota_trim_cal.sv
// tb_dota_trim_cal: self-checking bench for dota_trim_cal (N_CH=4, TRIM_W=6,
// SETTLE_CYC=8). The OTA plant is modelled as cmp_in[c] = code[c] > target[c].
module tb_dota_trim_cal;

    localparam int N    = 4;
    localparam int TW   = 6;
    localparam int SC   = 8;
`ifdef DOTA_CAL_MAJ3_EN
    localparam int DC       = 3;
    localparam int LAT_LIT  = 265;
    localparam int BUSY_LIT = 264;
`else
    localparam int DC       = 1;
    localparam int LAT_LIT  = 217;
    localparam int BUSY_LIT = 216;
`endif
    localparam int BC   = SC + DC;
    localparam int CHC  = TW * BC;
    localparam int L    = N * CHC + 1;
    localparam int MID  = 1 << (TW - 1);
    localparam int MAXC = (1 << TW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dota_trim_cal_if #(.N_CH(N), .TRIM_W(TW)) bus ();

    dota_trim_cal #(.N_CH(N), .TRIM_W(TW), .SETTLE_CYC(SC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    int tgt   [N];
    int mcode [N];
    int mprev [N];
    bit merr  [N];
    bit mcal  = 1'b0;
    int mk    = 0;
    bit chk_en = 1'b0;
    logic glitch_r = 1'b0;
    logic [N-1:0] cmp_v;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // SAR trial code after b decisions: resolved top bits of target plus the
    // next trial bit set.
    function automatic int trial(input int t, input int b);
        int sh;
        sh = TW - b;
        return ((t >> sh) << sh) | (1 << (TW - 1 - b));
    endfunction

    // Plant: comparator per channel, optionally glitched on the first sample
    // of each decision window.
    always_comb begin
        for (int c = 0; c < N; c++) begin
            cmp_v[c] = (int'(bus.trim_code[c*TW +: TW]) > tgt[c]) ^ glitch_r;
        end
        bus.cmp_in = cmp_v;
    end

    // Model update at each clock edge from the inputs of the ending cycle.
    always @(posedge clk) begin
        if (rst) begin
            mcal   = 1'b0;
            mk     = 0;
            chk_en = 1'b1;
            for (int c = 0; c < N; c++) begin
                mcode[c] = MID;
                merr[c]  = 1'b0;
            end
        end else if (mcal) begin
            if (mk == L) begin
                mcal = 1'b0;
            end else begin
                mk++;
                if (mk == L) begin
                    for (int c = 0; c < N; c++) begin
                        mcode[c] = tgt[c];
                        merr[c]  = (tgt[c] == 0) || (tgt[c] == MAXC);
                    end
                end
            end
        end else begin
            if (bus.start) begin
                mcal = 1'b1;
                mk   = 1;
                for (int c = 0; c < N; c++) begin
                    mprev[c] = mcode[c];
                    merr[c]  = 1'b0;
                end
            end else if (bus.wr_en && int'(bus.wr_ch) < N) begin
                mcode[bus.wr_ch] = int'(bus.wr_code);
            end
        end
    end

    // Compare every cycle against the model.
    always @(negedge clk) begin
        int ech, j, b, ebusy, edone, ecode;
        logic [N*TW-1:0] ef;
        logic [N-1:0] ee;
        ech = 0; ebusy = 0; edone = 0; ef = '0; ee = '0;
        for (int c = 0; c < N; c++) begin
            ef[c*TW +: TW] = TW'(mcode[c]);
            ee[c] = merr[c];
        end
        if (mcal && mk < L) begin
            ebusy = 1;
            ech = (mk - 1) / CHC;
            j   = (mk - 1) % CHC;
            b   = j / BC;
            for (int c = 0; c < N; c++) begin
                if (c < ech) begin
                    ecode = tgt[c];
                    ee[c] = (tgt[c] == 0) || (tgt[c] == MAXC);
                end else if (c == ech) begin
                    ecode = trial(tgt[c], b);
                    ee[c] = 1'b0;
                end else begin
                    ecode = mprev[c];
                    ee[c] = 1'b0;
                end
                ef[c*TW +: TW] = TW'(ecode);
            end
        end else if (mcal && mk == L) begin
            edone = 1;
        end
        if (chk_en) begin
            chk("m_trim", int'(bus.trim_code), int'(ef));
            chk("m_busy", int'(bus.busy), ebusy);
            chk("m_done", int'(bus.done), edone);
            chk("m_cur_ch", int'(bus.cur_ch), ech);
            chk("m_cal_err", int'(bus.cal_err), int'(ee));
        end
        glitch_r = (DC == 3) && mcal && (mk < L) && (((mk - 1) % BC) == SC);
    end

    task automatic run_cal(input bit disturb, input bit with_wr, input int keep3,
                           output int lat, output int nbusy);
        int n;
        bus.start = 1'b1;
        if (with_wr) begin
            bus.wr_en   = 1'b1;
            bus.wr_ch   = 2'd3;
            bus.wr_code = 6'd9;
        end
        @(negedge clk);
        bus.start = 1'b0;
        bus.wr_en = 1'b0;
        n = 1; lat = -1; nbusy = 0;
        if (with_wr) chk("drop_wr", int'(bus.trim_code[3*TW +: TW]), keep3);
        while (n < 600) begin
            if (bus.busy) nbusy++;
            if (bus.done) begin
                lat = n;
                break;
            end
            if (disturb && n == 50) begin
                bus.start   = 1'b1;
                bus.wr_en   = 1'b1;
                bus.wr_ch   = 2'd1;
                bus.wr_code = 6'd7;
            end
            @(negedge clk);
            bus.start = 1'b0;
            bus.wr_en = 1'b0;
            n++;
        end
    endtask

    initial begin
        int lat, nb, ndone;
        bus.start = 1'b0; bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_code = '0;
        for (int c = 0; c < N; c++) tgt[c] = 0;
        repeat (3) @(negedge clk);
        chk("rst_trim", int'(bus.trim_code), int'({6'd32, 6'd32, 6'd32, 6'd32}));
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_err", int'(bus.cal_err), 0);
        rst = 1'b0;
        @(negedge clk);

        tgt = '{37, 10, 50, 21};
        run_cal(1'b0, 1'b0, 0, lat, nb);
        chk("cal1_lat", lat, LAT_LIT);
        chk("cal1_busy_cycles", nb, BUSY_LIT);
        chk("cal1_codes", int'(bus.trim_code), int'({6'd21, 6'd50, 6'd10, 6'd37}));
        chk("cal1_err", int'(bus.cal_err), 0);
        repeat (3) @(negedge clk);

        tgt = '{63, 0, 31, 32};
        run_cal(1'b0, 1'b0, 0, lat, nb);
        chk("cal2_lat", lat, LAT_LIT);
        chk("cal2_codes", int'(bus.trim_code), int'({6'd32, 6'd31, 6'd0, 6'd63}));
        chk("cal2_err", int'(bus.cal_err), 3);
        repeat (3) @(negedge clk);

        tgt = '{37, 10, 50, 21};
        run_cal(1'b1, 1'b0, 0, lat, nb);
        chk("cal3_lat", lat, LAT_LIT);
        chk("cal3_busy_cycles", nb, BUSY_LIT);
        chk("cal3_codes", int'(bus.trim_code), int'({6'd21, 6'd50, 6'd10, 6'd37}));
        chk("cal3_err", int'(bus.cal_err), 0);
        repeat (3) @(negedge clk);

        bus.wr_en = 1'b1; bus.wr_ch = 2'd2; bus.wr_code = 6'd5;
        @(negedge clk);
        bus.wr_en = 1'b0;
        chk("wr_ch2", int'(bus.trim_code[2*TW +: TW]), 5);
        chk("wr_busy", int'(bus.busy), 0);
        @(negedge clk);

        tgt = '{1, 2, 3, 4};
        run_cal(1'b0, 1'b1, 21, lat, nb);
        chk("cal4_lat", lat, LAT_LIT);
        chk("cal4_codes", int'(bus.trim_code), int'({6'd4, 6'd3, 6'd2, 6'd1}));
        repeat (3) @(negedge clk);

        tgt = '{37, 10, 50, 21};
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (99) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mrst_trim", int'(bus.trim_code), int'({6'd32, 6'd32, 6'd32, 6'd32}));
        chk("mrst_busy", int'(bus.busy), 0);
        ndone = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.done) ndone++;
        end
        chk("mrst_no_done", ndone, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
